// File: rtl/rad_pulse_pkg.sv
// rad_pulse_pkg: shared types and defaults for the toggle-based pulse crossing.
//   rad_pulse_tx_state_e : sender FSM states (StIdle, StWaitAck)
//   RAD_PULSE_CNT_W_DEF  : default width of the sender's pending-event counter
//   rad_pulse_cnt_max()  : saturation value of a counter of the given width
package rad_pulse_pkg;

  localparam int unsigned RAD_PULSE_CNT_W_DEF = 4;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StWaitAck = 1'b1
  } rad_pulse_tx_state_e;

  function automatic int unsigned rad_pulse_cnt_max(int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/rad_pulse_tx_if.sv
// rad_pulse_tx_if: event/acknowledge/status bundle of the pulse-crossing sender.
//   ev_pulse  : 1-cycle event request into the sender
//   ack_tgl   : acknowledge toggle, already synchronized to the sender clock
//   req_tgl   : request toggle towards the crossing
//   busy      : a request is outstanding
//   pend_cnt  : queued events not yet issued
//   drop      : 1-cycle pulse, event lost to a saturated counter
//   err       : 1-cycle pulse, unexpected or mismatched acknowledge edge
//   ovf       : sticky drop flag (tied low unless RAD_PULSE_TX_OVF_EN)
// Modports: master = the sender itself, slave = its environment.
interface rad_pulse_tx_if
  import rad_pulse_pkg::*;
#(
  parameter int unsigned CNT_W = RAD_PULSE_CNT_W_DEF
);

  logic             ev_pulse;
  logic             ack_tgl;
  logic             req_tgl;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             drop;
  logic             err;
  logic             ovf;

  modport master (
    input  ev_pulse,
    input  ack_tgl,
    output req_tgl,
    output busy,
    output pend_cnt,
    output drop,
    output err,
    output ovf
  );

  modport slave (
    output ev_pulse,
    output ack_tgl,
    input  req_tgl,
    input  busy,
    input  pend_cnt,
    input  drop,
    input  err,
    input  ovf
  );

endinterface

// File: rtl/rad_pulse_gen.sv
// rad_pulse_gen: toggle-to-pulse edge detector.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : toggle input (already synchronous to clk)
//   q     : d registered
//   pulse : combinational d ^ q, high in the cycle a toggle becomes visible
module rad_pulse_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic pulse
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign pulse = d ^ q;

endmodule

// File: rtl/rad_pulse_tx.sv
// rad_pulse_tx: source-side sender for a toggle-based pulse crossing.
// Event pulses are queued in a saturating counter; each one is sent as a single
// level toggle on req_tgl, held until a matching acknowledge toggle returns.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rad_pulse_tx_if.master (ev_pulse, ack_tgl in; req_tgl, busy, pend_cnt,
//         drop, err, ovf out)
// Parameter CNT_W: pending counter width, saturates at 2^CNT_W-1.
// Build option RAD_PULSE_TX_OVF_EN: when defined, ovf is a sticky flag set by any
// drop and cleared only by rst; otherwise ovf is tied low and no register exists.
module rad_pulse_tx
  import rad_pulse_pkg::*;
#(
  parameter int unsigned CNT_W = RAD_PULSE_CNT_W_DEF
) (
  input logic            clk,
  input logic            rst,
  rad_pulse_tx_if.master bus
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(rad_pulse_cnt_max(CNT_W));

  rad_pulse_tx_state_e state_q, state_d;
  logic                req_q, req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic                err_q, err_d;

  logic rst_n;
  logic ack_q;
  logic ack_edge;
  logic ack_match;
  logic cnt_nz;
  logic cnt_full;
  logic issue;
  logic issue_cnt;
  logic ev_to_cnt;
  logic ev_accept;

  // Acknowledge edge detection
  assign rst_n = ~rst;

  rad_pulse_gen u_ack_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.ack_tgl),
    .q     (ack_q),
    .pulse (ack_edge)
  );

  // On an edge ack_tgl == ~ack_q, so "ack_tgl equals req" is "ack_q differs from req".
  assign ack_match = ack_q ^ req_q;

  assign cnt_nz   = (cnt_q != '0);
  assign cnt_full = (cnt_q == CntMax);

  // FSM next state
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    err_d   = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An ack edge here is unexpected; it is flagged but does not move the FSM.
        err_d = ack_edge;
        if (cnt_nz || bus.ev_pulse) begin
          issue   = 1'b1;
          req_d   = ~req_q;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (ack_edge) begin
          if (ack_match) begin
            state_d = StIdle;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pending counter
  always_comb begin
    // Queued events go out before a new one; a new event only bypasses the counter
    // when nothing is queued.
    issue_cnt = issue & cnt_nz;
    ev_to_cnt = bus.ev_pulse & ~(issue & ~cnt_nz);
    // A full counter still takes the event when one slot is freed this cycle.
    ev_accept = ev_to_cnt & (~cnt_full | issue_cnt);
    drop_d    = ev_to_cnt & cnt_full & ~issue_cnt;
    cnt_d     = cnt_q;
    if (ev_accept && !issue_cnt) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!ev_accept && issue_cnt) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

`ifdef RAD_PULSE_TX_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop_d) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.req_tgl  = req_q;
  assign bus.busy     = (state_q == StWaitAck);
  assign bus.pend_cnt = cnt_q;
  assign bus.drop     = drop_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_rad_pulse_tx.sv
// Testbench for rad_pulse_tx: directed test-plan steps followed by a random phase,
// all compared cycle by cycle against an event-level reference model.
module tb_rad_pulse_tx;

  localparam int unsigned CNT_W = 2;
  localparam int          MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  rad_pulse_tx_if #(.CNT_W(CNT_W)) bus ();

  rad_pulse_tx #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: outstanding flag, toggle level, queue depth
  bit m_busy, m_req, m_ack_prev, m_drop, m_err, m_ovf;
  int m_pend;

  // Responder and observation state
  bit ack_lvl;
  bit auto_ack;
  int fixed_dly;
  int resp_cnt, resp_dly;
  logic prev_req;
  int req_edges, drops_seen, peak;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_ack_prev = 0; m_drop = 0; m_err = 0; m_ovf = 0; m_pend = 0;
  endtask

  task automatic model_cycle(bit ev, bit ack);
    bit edge_m = (ack != m_ack_prev);
    bit n_drop = 1'b0;
    bit n_err  = 1'b0;
    if (!m_busy) begin
      if (edge_m) n_err = 1'b1;
      if (m_pend > 0) begin
        // oldest queued event goes out; a simultaneous new one takes its place
        m_req  = ~m_req;
        m_busy = 1'b1;
        if (!ev) m_pend--;
      end else if (ev) begin
        m_req  = ~m_req;
        m_busy = 1'b1;
      end
    end else begin
      if (edge_m) begin
        if (ack == m_req) m_busy = 1'b0;
        else n_err = 1'b1;
      end
      if (ev) begin
        if (m_pend < MAX) m_pend++;
        else n_drop = 1'b1;
      end
    end
    m_ack_prev = ack;
    m_drop = n_drop;
    m_err  = n_err;
`ifdef RAD_PULSE_TX_OVF_EN
    m_ovf = m_ovf | n_drop;
`endif
  endtask

  task automatic check_all();
    chk("req_tgl", 32'(bus.req_tgl), 32'(m_req));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("pend_cnt", 32'(bus.pend_cnt), 32'(m_pend));
    chk("drop", 32'(bus.drop), 32'(m_drop));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_req"}, 32'(bus.req_tgl), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_pend"}, 32'(bus.pend_cnt), 32'd0);
    chk({tag, "_drop"}, 32'(bus.drop), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  // One clock cycle: responder decides ack, inputs driven, model stepped, outputs checked.
  task automatic tick(bit ev);
    if (auto_ack && m_busy) begin
      if (resp_cnt == 0) resp_dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 5));
      if (resp_cnt >= resp_dly) begin
        ack_lvl  = ~ack_lvl;
        resp_cnt = 0;
      end else begin
        resp_cnt++;
      end
    end else begin
      resp_cnt = 0;
    end
    bus.ev_pulse = ev;
    bus.ack_tgl  = ack_lvl;
    @(posedge clk);
    model_cycle(ev, ack_lvl);
    #1;
    cyc++;
    check_all();
    if (bus.req_tgl !== prev_req) req_edges++;
    prev_req = bus.req_tgl;
    if (int'(bus.pend_cnt) > peak) peak = int'(bus.pend_cnt);
    if (bus.drop === 1'b1) drops_seen++;
  endtask

  initial begin
    bit exp_ovf;
`ifdef RAD_PULSE_TX_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    rst = 1'b1;
    bus.ev_pulse = 1'b0;
    bus.ack_tgl  = 1'b0;
    ack_lvl   = 1'b0;
    auto_ack  = 1'b0;
    fixed_dly = 3;
    resp_cnt  = 0;
    resp_dly  = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    prev_req = 1'b0;

    // Single event, then acknowledge
    repeat (4) tick(1'b0);
    tick(1'b1);
    chk("single_req", 32'(bus.req_tgl), 32'd1);
    chk("single_busy", 32'(bus.busy), 32'd1);
    repeat (3) tick(1'b0);
    ack_lvl = 1'b1;
    tick(1'b0);
    chk("single_idle", 32'(bus.busy), 32'd0);
    chk("single_pend", 32'(bus.pend_cnt), 32'd0);

    // Four back-to-back events with a fixed-latency responder
    req_edges = 0; drops_seen = 0; peak = 0;
    auto_ack = 1'b1;
    fixed_dly = 3;
    repeat (4) tick(1'b1);
    repeat (40) tick(1'b0);
    chk("b2b_peak", 32'(peak), 32'd3);
    chk("b2b_edges", 32'(req_edges), 32'd4);
    chk("b2b_pend_end", 32'(bus.pend_cnt), 32'd0);
    chk("b2b_drops", 32'(drops_seen), 32'd0);

    // Saturation with acknowledge withheld
    auto_ack = 1'b0;
    repeat (4) tick(1'b1);
    chk("sat_pend4", 32'(bus.pend_cnt), 32'd3);
    chk("sat_nodrop4", 32'(bus.drop), 32'd0);
    tick(1'b1);
    chk("sat_pend5", 32'(bus.pend_cnt), 32'd3);
    chk("sat_drop5", 32'(bus.drop), 32'd1);
    chk("sat_ovf", 32'(bus.ovf), 32'(exp_ovf));
    tick(1'b0);
    chk("sat_drop_clr", 32'(bus.drop), 32'd0);

    // Counter full, event coincides with an issue from the counter
    ack_lvl = ~ack_lvl;
    tick(1'b0);
    chk("coin_idle", 32'(bus.busy), 32'd0);
    tick(1'b1);
    chk("coin_pend", 32'(bus.pend_cnt), 32'd3);
    chk("coin_drop", 32'(bus.drop), 32'd0);
    chk("coin_busy", 32'(bus.busy), 32'd1);
    auto_ack = 1'b1;
    fixed_dly = -1;
    repeat (80) tick(1'b0);
    chk("drain_pend", 32'(bus.pend_cnt), 32'd0);
    chk("drain_busy", 32'(bus.busy), 32'd0);

    // Spurious acknowledge while idle
    begin
      logic r0;
      r0 = bus.req_tgl;
      auto_ack = 1'b0;
      ack_lvl = ~ack_lvl;
      tick(1'b0);
      chk("idle_err", 32'(bus.err), 32'd1);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_req", 32'(bus.req_tgl), 32'(r0));
      tick(1'b0);
      chk("idle_err_clr", 32'(bus.err), 32'd0);
    end

    // Reset in the middle of a wait with two events queued
    repeat (3) tick(1'b1);
    chk("mid_pend", 32'(bus.pend_cnt), 32'd2);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.ev_pulse = 1'b0;
    ack_lvl = 1'b0;
    bus.ack_tgl = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_req = 1'b0;
    tick(1'b1);
    chk("post_rst_req", 32'(bus.req_tgl), 32'd1);

    // Random traffic, responder latency, hold-off windows and stray ack flips
    auto_ack = 1'b1;
    fixed_dly = -1;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) auto_ack = ($urandom_range(0, 3) != 0);
      if (!m_busy && $urandom_range(0, 49) == 0) ack_lvl = ~ack_lvl;
      tick($urandom_range(0, 99) < 40);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rad_pulse_tx.md
# rad_pulse_tx

Source-side sender for toggle-based pulse crossing. Accepts single-cycle event pulses, queues them in a saturating pending counter, and emits one level toggle per event on `req_tgl`. Each toggle is held until the destination returns a matching acknowledge toggle, already synchronized into this clock. It sits directly upstream of the destination's toggle-to-pulse generator; that generator's registered toggle, brought back through an external 2-flop synchronizer, drives `ack_tgl`.

## Interface
- `CNT_W`, default 4: width of pending-event counter; max pending = 2^CNT_W-1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; **asynchronous, active-high**; single clock domain.
- `ev_pulse`  in  1  event request; 1-cycle pulses, may be asserted back-to-back.
- `ack_tgl`  in  1  acknowledge toggle, synchronized to `clk` externally.
- `req_tgl`  out  1  request toggle to the crossing; registered.
- `busy`  out  1  high in WAIT_ACK.
- `pend_cnt`  out  CNT_W  queued events not yet issued.
- `drop`  out  1  1-cycle pulse: event lost because the counter is saturated.
- `err`  out  1  1-cycle pulse: ack edge with no outstanding request, or ack value != `req_tgl`.
- `ovf`  out  1  sticky drop flag; present only with the macro, see Configuration.

## Operation
- Ack edge: `ack_edge = ack_tgl ^ ack_q`, where `ack_q` is `ack_tgl` registered.
- FSM states: IDLE, WAIT_ACK.
- Issue condition: in IDLE with (`pend_cnt` > 0 or `ev_pulse`).
  - `req_tgl` inverts.
  - State goes to WAIT_ACK.
  - One event is consumed.
- An event arriving in IDLE with `pend_cnt`=0 is issued directly; the counter is untouched.
- WAIT_ACK:
  - `ack_edge` with `ack_tgl == req_tgl` returns the FSM to IDLE.
  - `ack_edge` with `ack_tgl != req_tgl` pulses `err`; the FSM stays in WAIT_ACK.
- `ack_edge` in IDLE pulses `err`; the FSM state does not change.
- Counter update per cycle:
  - `pend_cnt += ev_pulse_accepted − issue_from_counter`.
  - An event and an issue in the same cycle leave the count unchanged.
- Saturation: `ev_pulse` when `pend_cnt` = max and no issue from the counter this cycle.
  - `drop` pulses.
  - Count stays at max.
  - If an issue happens in the same cycle, the event is accepted.
- No wrap-around: the counter never increments past max and never decrements below 0.
- Reset values: `req_tgl`=0, `ack_q`=0, state=IDLE, `pend_cnt`=0, `busy`=0, `drop`=0, `err`=0, `ovf`=0.
- Reset mid-operation clears all state; pending events are lost. The destination must be reset in the same window so both toggle levels start at 0.

## Timing
- `ev_pulse` in cycle N, IDLE, `pend_cnt`=0: `req_tgl` and `busy` change at the edge ending N (visible in N+1).
- `ack_tgl` changes visible in cycle M:
  - `err`/state decision made combinationally in M.
  - IDLE from M+1.
  - Next queued issue toggles `req_tgl` visible at M+2.
- Back-to-back throughput: one event per (round trip + 2) cycles.
- `drop` and `err` are combinational from registered state plus inputs. They are registered to align with the cycle after the cause: pulse visible in N+1 for a cause in N.
- `pend_cnt` and `busy` are registered.

## Configuration
- `RAD_PULSE_TX_OVF_EN` defined:
  - `ovf` sets on any `drop`.
  - Cleared only by `rst`.
- Undefined:
  - `ovf` port remains, tied to 0.
  - No sticky register is built.
  - `drop` is still generated.

## Structure
- Shared package `rad_pulse_pkg`:
  - FSM state enum `rad_pulse_tx_state_e` (IDLE, WAIT_ACK).
  - Default `RAD_PULSE_CNT_W_DEF` = 4.
- Ack edge detection reuses `rad_pulse_gen`:
  - `d`=`ack_tgl`, `q`=`ack_q`, `pulse`=`ack_edge`, `rst_n` = `!rst`.
- The pending counter and FSM stay in the top module.

## Test plan
- Reset, then single `ev_pulse` at cycle 5 -> `req_tgl` 0->1 and `busy`=1 visible at cycle 6. `ack_tgl`->1 at cycle 10 -> `busy`=0 at 11, `pend_cnt` stays 0.
- 4 back-to-back `ev_pulse` with ack 3 cycles after each toggle -> `pend_cnt` peaks at 3, exactly 4 `req_tgl` transitions, ends 0, no `drop`.
- CNT_W=2, hold ack off, 5 events -> 1 issued, `pend_cnt`=3; the 5th event pulses `drop`. `ovf`=1 with the macro, 0 without.
- Counter at 3, event in the same cycle as an issue from the counter -> `pend_cnt` stays 3, no `drop`.
- `ack_tgl` flip while IDLE -> `err` pulses once, state unchanged, `req_tgl` unchanged.
- Assert `rst` mid-WAIT_ACK with `pend_cnt`=2 -> all outputs at reset values immediately (async). After release, a new event toggles `req_tgl` 0->1.
